minterm_checker: RTL

MINTERM_CHECKER -- requirements
Module: minterm_checker

---
 rtl/minterm_pkg.sv | 14 +
 rtl/minterm_ref.sv | 14 +
 rtl/minterm_checker.sv | 113 +++++++++++
 3 files changed

// File: rtl/minterm_pkg.sv
// minterm_pkg: shared types and constants for the minterm checker.
//   state_e               - checker FSM states (IDLE, RUN, DONE)
//   MINTERM_SUM_0_1_3_8_9 - truth table of sum(0,1,3,8,9); bit n is Q for A=n
package minterm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] MINTERM_SUM_0_1_3_8_9 = 16'h030B;

endpackage

// File: rtl/minterm_ref.sv
// minterm_ref: combinational reference model of a 4-input function given
// as a 16-entry truth table.
//   a        in  [3:0]  function input
//   mask     in  [15:0] truth table, bit n is the output for a == n
//   expected out        mask[a]
module minterm_ref (
    input  logic [3:0]  a,
    input  logic [15:0] mask,
    output logic        expected
);

    assign expected = mask[a];

endmodule

// File: rtl/minterm_checker.sv
// minterm_checker: accepts NUM_VECTORS observed (A, Q) pairs from a unit
// under test, compares each Q against the truth table EXPECT_MASK and
// reports vector/mismatch counts and an overall pass flag.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse that begins a run (ignored in RUN)
//   in_valid/in_ready vector handshake; accept on in_valid && in_ready
//   in_a, in_q        observed stimulus and response
//   busy              run in progress
//   done, pass        run complete / complete with zero mismatches
//   vec_count         vectors accepted in current or last run
//   err_count         mismatches in current or last run
//   first_fail_a      in_a of the first mismatch of the run
//   first_fail_valid  first_fail_a holds a captured value
//
// Build option: define MINTERM_CHECKER_FIRST_FAIL_EN to enable capture of
// the first failing vector; otherwise first_fail_* are tied to 0.
module minterm_checker
    import minterm_pkg::*;
#(
    parameter logic [15:0] EXPECT_MASK = MINTERM_SUM_0_1_3_8_9,
    parameter int          NUM_VECTORS = 5,
    parameter int          COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_a,
    input  logic               in_q,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] vec_count,
    output logic [COUNT_W-1:0] err_count,
    output logic [3:0]         first_fail_a,
    output logic               first_fail_valid
);

    localparam logic [COUNT_W-1:0] LAST_VEC = COUNT_W'(NUM_VECTORS);

    state_e             state;
    logic               accept;
    logic               expected;
    logic               mismatch;
    logic               launch;
    logic [COUNT_W-1:0] vec_next;

    minterm_ref u_ref (
        .a        (in_a),
        .mask     (EXPECT_MASK),
        .expected (expected)
    );

    // An unknown in_q makes the equality test non-true, so the else branch
    // flags it as a mismatch.
    always_comb begin
        mismatch = 1'b1;
        if (in_q == expected)
            mismatch = 1'b0;
    end

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    // Built only from registers, so it changes on the same edge as done.
    assign pass     = done && (err_count == '0);
    assign accept   = in_valid && in_ready;
    assign launch   = start && (state != RUN);
    assign vec_next = vec_count + COUNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec_count <= '0;
            err_count <= '0;
        end else if (launch) begin
            state     <= RUN;
            vec_count <= '0;
            err_count <= '0;
        end else if (accept) begin
            vec_count <= vec_next;
            if (mismatch)
                err_count <= err_count + COUNT_W'(1);
            if (vec_next == LAST_VEC)
                state <= DONE;
        end
    end

`ifdef MINTERM_CHECKER_FIRST_FAIL_EN
    logic [3:0] ff_a_q;
    logic       ff_v_q;

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            ff_a_q <= '0;
            ff_v_q <= 1'b0;
        end else if (accept && mismatch && !ff_v_q) begin
            ff_a_q <= in_a;
            ff_v_q <= 1'b1;
        end
    end

    assign first_fail_a     = ff_a_q;
    assign first_fail_valid = ff_v_q;
`else
    assign first_fail_a     = 4'd0;
    assign first_fail_valid = 1'b0;
`endif

endmodule
